// File: rtl/pc_branch_unit.sv
// Fetch/control stage: program counter, branch-target LUT, carry flag and start/done run control.
// Optional RUN-cycle counter enabled by defining PC_CYCLE_CNT_EN; otherwise cycle_cnt_o is tied to zero.
//
// state | meaning
// IDLE  | after reset, PC held, waiting for start
// RUN   | fetching; PC advances or redirects each unstalled cycle
// DONE  | halt retired, PC held, waiting for start
module pc_branch_unit #(
    parameter int PC_W       = 10,
    parameter int LUT_IDX_W  = 4,
    parameter int START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 jump_i,
    input  logic                 branch_i,
    input  logic                 branch_ne_i,
    input  logic                 equal_i,
    input  logic [LUT_IDX_W-1:0] target_idx_i,
    input  logic                 lut_we_i,
    input  logic [LUT_IDX_W-1:0] lut_widx_i,
    input  logic [PC_W-1:0]      lut_wdata_i,
    input  logic                 sc_we_i,
    input  logic                 sc_clr_i,
    input  logic                 sc_d_i,
    output logic                 sc_q_o,
    output logic [PC_W-1:0]      pc_o,
    output logic                 taken_o,
    output logic                 running_o,
    output logic                 done_o,
    output logic [15:0]          cycle_cnt_o
);

    localparam int LUT_DEPTH = 2 ** LUT_IDX_W;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            sc_flag_q, sc_flag_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic            advance;

    // A stalled or halting cycle never redirects, so jump and branch only matter when advancing.
    assign advance = (state_q == RUN) && !stall_i && !halt_i;
    assign taken_o = advance && (jump_i || (branch_i && (equal_i ^ branch_ne_i)));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sc_flag_d = sc_flag_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    if (halt_i) begin
                        state_d = DONE;
                    end else if (taken_o) begin
                        pc_d = lut_q[target_idx_i];
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                    if (sc_clr_i) begin
                        sc_flag_d = 1'b0;
                    end else if (sc_we_i) begin
                        sc_flag_d = sc_d_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            sc_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sc_flag_q <= sc_flag_d;
        end
    end

    // Registered LUT with combinational read: a same-cycle write is seen from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_q <= '{default: '0};
        end else if (lut_we_i) begin
            lut_q[lut_widx_i] <= lut_wdata_i;
        end
    end

`ifdef PC_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != RUN) && start) begin
            cnt_d = 16'h0000;
        end else if ((state_q == RUN) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt_o = cnt_q;
`else
    assign cycle_cnt_o = 16'h0000;
`endif

    assign pc_o      = pc_q;
    assign sc_q_o    = sc_flag_q;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector bench for pc_branch_unit: table of per-cycle inputs and expected outputs,
// plus hand-written sequences for reset, same-cycle LUT write/read and the cycle counter.
module tb_pc_branch_unit;

    localparam int PC_W = 10;
    localparam int IW   = 4;

    logic            clk = 1'b0;
    logic            reset, start, stall_i, halt_i, jump_i, branch_i, branch_ne_i, equal_i;
    logic [IW-1:0]   target_idx_i, lut_widx_i;
    logic            lut_we_i, sc_we_i, sc_clr_i, sc_d_i;
    logic [PC_W-1:0] lut_wdata_i;
    logic            sc_q_o, taken_o, running_o, done_o;
    logic [PC_W-1:0] pc_o;
    logic [15:0]     cycle_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    pc_branch_unit #(.PC_W(PC_W), .LUT_IDX_W(IW), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .stall_i(stall_i), .halt_i(halt_i),
        .jump_i(jump_i), .branch_i(branch_i), .branch_ne_i(branch_ne_i), .equal_i(equal_i),
        .target_idx_i(target_idx_i), .lut_we_i(lut_we_i), .lut_widx_i(lut_widx_i),
        .lut_wdata_i(lut_wdata_i), .sc_we_i(sc_we_i), .sc_clr_i(sc_clr_i), .sc_d_i(sc_d_i),
        .sc_q_o(sc_q_o), .pc_o(pc_o), .taken_o(taken_o), .running_o(running_o),
        .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            st, sl, hl, jp, br, ne, eq;
        logic [IW-1:0]   idx;
        logic            we, clr, d;
        logic            e_taken;
        logic [PC_W-1:0] e_pc;
        logic            e_run, e_done, e_sc;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(input logic st, sl, hl, jp, br, ne, eq, input int idx,
                                input logic we, clr, d, input logic e_taken, input int e_pc,
                                input logic e_run, e_done, e_sc);
        vec_t v;
        v.st = st; v.sl = sl; v.hl = hl; v.jp = jp; v.br = br; v.ne = ne; v.eq = eq;
        v.idx = IW'(idx); v.we = we; v.clr = clr; v.d = d;
        v.e_taken = e_taken; v.e_pc = PC_W'(e_pc);
        v.e_run = e_run; v.e_done = e_done; v.e_sc = e_sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        start = v.st; stall_i = v.sl; halt_i = v.hl; jump_i = v.jp; branch_i = v.br;
        branch_ne_i = v.ne; equal_i = v.eq; target_idx_i = v.idx;
        sc_we_i = v.we; sc_clr_i = v.clr; sc_d_i = v.d;
        #1;
        check({tag, " taken"}, 32'(taken_o), 32'(v.e_taken));
        @(posedge clk);
        #1;
        check({tag, " pc"}, 32'(pc_o), 32'(v.e_pc));
        check({tag, " running"}, 32'(running_o), 32'(v.e_run));
        check({tag, " done"}, 32'(done_o), 32'(v.e_done));
        check({tag, " sc"}, 32'(sc_q_o), 32'(v.e_sc));
`ifndef PC_CYCLE_CNT_EN
        check({tag, " cnt"}, 32'(cycle_cnt_o), 32'h0);
`endif
    endtask

    task automatic write_lut(input int idx, input int data);
        @(negedge clk);
        lut_we_i = 1'b1; lut_widx_i = IW'(idx); lut_wdata_i = PC_W'(data);
        @(posedge clk);
        #1;
        lut_we_i = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, " pc"}, 32'(pc_o), 32'h0);
        check({tag, " sc"}, 32'(sc_q_o), 32'h0);
        check({tag, " running"}, 32'(running_o), 32'h0);
        check({tag, " done"}, 32'(done_o), 32'h0);
        check({tag, " cnt"}, 32'(cycle_cnt_o), 32'h0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall_i = 1'b0; halt_i = 1'b0; jump_i = 1'b0;
        branch_i = 1'b0; branch_ne_i = 1'b0; equal_i = 1'b0; target_idx_i = '0;
        sc_we_i = 1'b0; sc_clr_i = 1'b0; sc_d_i = 1'b0;
        // LUT write attempted during reset must be dropped
        lut_we_i = 1'b1; lut_widx_i = IW'(9); lut_wdata_i = PC_W'(77);

        //            st sl hl jp br ne eq idx we cl d   tk pc     run dn sc
        tbl_a.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,     1, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1,     1, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1,  0, 2,     1, 0, 1));
        tbl_a.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 3,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1,  0, 4,     1, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1,  0, 5,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 1, 3,  0, 0, 0,  1, 'h155, 1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4,  0, 0, 0,  1, 5,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3,  0, 0, 0,  0, 6,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 7,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2,  0, 0, 0,  1, 40,    1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 6,  0, 0, 0,  1, 7,     1, 0, 1));
        tbl_a.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2,  1, 1, 0,  0, 7,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2,  0, 0, 0,  0, 8,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3,  0, 0, 0,  1, 'h155, 1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5,  0, 0, 0,  1, 12,    1, 0, 1));
        tbl_a.push_back(mk(0, 0, 1, 1, 0, 0, 0, 3,  0, 0, 0,  0, 12,    0, 1, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  1, 0, 0,  0, 12,    0, 1, 1));
        tbl_a.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 9,  0, 0, 0,  1, 0,     1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 1, 0, 0, 0, 7,  0, 0, 0,  1, 'h3FE, 1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 'h3FF, 1, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,     1, 0, 1));

        // after the mid-run reset: LUT must read back as zero
        tbl_b.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,     1, 0, 0));
        tbl_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  0, 0, 0,  1, 0,     1, 0, 0));
        tbl_b.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 1,     1, 0, 0));
        tbl_b.push_back(mk(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 0,  1, 0,     1, 0, 0));
        tbl_b.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0,     0, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_idle_reset("reset");
        @(negedge clk);
        reset = 1'b0; lut_we_i = 1'b0;
        @(posedge clk);
        #1;
        check("idle pc", 32'(pc_o), 32'h0);
        check("idle running", 32'(running_o), 32'h0);

        write_lut(2, 40);
        write_lut(3, 'h155);
        write_lut(4, 5);
        write_lut(5, 12);
        write_lut(6, 7);
        write_lut(7, 'h3FE);
        write_lut(8, 200);
        write_lut(10, 9);

        for (int i = 0; i < tbl_a.size(); i++) begin
            apply($sformatf("a%0d", i), tbl_a[i]);
        end

        // same-cycle write and read of LUT[8]: old entry used now, new entry next time
        @(negedge clk);
        start = 1'b0; stall_i = 1'b0; halt_i = 1'b0; branch_i = 1'b0;
        sc_we_i = 1'b0; sc_clr_i = 1'b0;
        jump_i = 1'b1; target_idx_i = IW'(8);
        lut_we_i = 1'b1; lut_widx_i = IW'(8); lut_wdata_i = PC_W'(100);
        #1;
        check("wr-rd taken", 32'(taken_o), 32'h1);
        @(posedge clk);
        #1;
        lut_we_i = 1'b0;
        check("wr-rd old pc", 32'(pc_o), 32'd200);
        apply("wr-rd new", mk(0, 0, 0, 1, 0, 0, 0, 8, 0, 0, 0, 1, 100, 1, 0, 1));
        apply("to9", mk(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 0, 1, 9, 1, 0, 1));

        // reset mid-RUN at pc=9, with start and a LUT write also present
        @(negedge clk);
        jump_i = 1'b0; reset = 1'b1; start = 1'b1;
        lut_we_i = 1'b1; lut_widx_i = IW'(10); lut_wdata_i = PC_W'(55);
        @(posedge clk);
        #1;
        check_idle_reset("midrun reset");
        @(negedge clk);
        reset = 1'b0; start = 1'b0; lut_we_i = 1'b0;
        @(posedge clk);
        #1;
        check("post reset running", 32'(running_o), 32'h0);
        check("post reset pc", 32'(pc_o), 32'h0);

        for (int i = 0; i < tbl_b.size(); i++) begin
            apply($sformatf("b%0d", i), tbl_b[i]);
        end

        // cycle counter: start from DONE, 2 stalled + 2 normal + halt = 5 RUN cycles
        apply("cnt start", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`ifdef PC_CYCLE_CNT_EN
        check("cnt cleared", 32'(cycle_cnt_o), 32'h0);
`endif
        apply("cnt s1", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        apply("cnt s2", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        apply("cnt n1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        apply("cnt n2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        apply("cnt halt", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
        apply("cnt hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0));
`ifdef PC_CYCLE_CNT_EN
        check("cnt done value", 32'(cycle_cnt_o), 32'd5);
        @(posedge clk);
        #1;
        check("cnt frozen", 32'(cycle_cnt_o), 32'd5);
`else
        check("cnt tied off", 32'(cycle_cnt_o), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Sequential fetch/control stage that consumes the ALU's `equal` comparison result and feeds the ALU its registered shift-carry input.
- Holds the program counter (PC), a loadable branch-target lookup table (LUT), the carry flag register and the start/done run-control FSM.
- The PC drives instruction-memory address; `sc_q_o` drives the ALU `sc_i`.

Parameters:
- PC_W, 10, PC width in bits; instruction memory depth is 2**PC_W.
- LUT_IDX_W, 4, branch-target LUT index width; the LUT has 2**LUT_IDX_W entries of PC_W bits.
- START_ADDR, 0, PC value loaded on every start.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  in IDLE or DONE: begin execution at START_ADDR.
- stall_i  in  1  freezes PC and carry-flag update for this cycle.
- halt_i  in  1  current instruction is halt.
- jump_i  in  1  unconditional jump via LUT.
- branch_i  in  1  conditional branch instruction.
- branch_ne_i  in  1  0 = beq (taken when equal_i=1); 1 = bne (taken when equal_i=0).
- equal_i  in  1  ALU equality result.
- target_idx_i  in  LUT_IDX_W  LUT index for jump/branch.
- lut_we_i  in  1  LUT write enable.
- lut_widx_i  in  LUT_IDX_W  LUT write index.
- lut_wdata_i  in  PC_W  LUT write data.
- sc_we_i  in  1  capture ALU carry-out.
- sc_clr_i  in  1  clear carry flag.
- sc_d_i  in  1  ALU `sc_o`.
- sc_q_o  out  1  registered carry flag, to ALU `sc_i`.
- pc_o  out  PC_W  current PC.
- taken_o  out  1  combinational: redirect to a LUT target this cycle.
- running_o  out  1  FSM is in RUN.
- done_o  out  1  FSM is in DONE.
- cycle_cnt_o  out  16  RUN cycle count (see Optional Feature).

Behaviour:
- Reset
  - The clock and reset arrangement is fixed: one clock, `clk`; reset `reset` is synchronous and active-high.
  - Reset takes priority over every other input. Reset mid-RUN aborts immediately.
  - Reset values: pc_o=START_ADDR, sc_q_o=0, running_o=0, done_o=0, cycle_cnt_o=0, all LUT entries=0, FSM=IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: PC held. start=1 -> RUN with pc=START_ADDR next cycle.
  - RUN, stall_i=1: PC and sc_q hold.
  - RUN, stall_i=0, halt_i=1: -> DONE; PC holds its current value.
  - RUN, stall_i=0, halt_i=0: PC updates by priority jump_i > taken branch > increment.
  - DONE: done_o=1 and PC held until start=1, which -> RUN with pc=START_ADDR and done_o=0 on the next cycle.
  - start is ignored while in RUN.
- Taken rule: taken_o = RUN & ~stall_i & ~halt_i & (jump_i | (branch_i & (equal_i ^ branch_ne_i))).
  - taken_o=1: next pc = LUT[target_idx_i].
  - Otherwise: next pc = pc+1, modulo 2**PC_W (2**PC_W-1 wraps to 0).
- Latency: redirect is visible on pc_o one cycle after taken_o.
- LUT
  - Writes are accepted in every state except during reset, and are independent of stall_i.
  - Combinational read. A same-cycle write and read of the same index returns the old entry; the new value is used from the next cycle.
- Carry flag
  - Updates only in RUN with stall_i=0.
  - sc_clr_i=1 -> 0 (beats sc_we_i).
  - Else sc_we_i=1 -> sc_d_i.
  - Else hold.
  - Held in IDLE and DONE.

Optional Feature:
- Macro: PC_CYCLE_CNT_EN.
- Defined:
  - 16-bit counter increments on every RUN cycle, including stalled cycles.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on start from IDLE/DONE; frozen in DONE.
- Undefined: counter logic is absent and cycle_cnt_o is tied to 16'h0000.

Test Plan:
- Reset then start=1 for 1 cycle, no branches -> pc_o=0,1,2,3 on successive cycles; running_o=1.
- LUT[3]=10'h155; at pc=5, branch_i=1, branch_ne_i=0, equal_i=1, target_idx_i=3 -> taken_o=1, next pc_o=10'h155. Same with equal_i=0 -> pc_o=6.
- bne at pc=7 with equal_i=0, LUT[2]=40 -> pc_o=40. stall_i=1 together with jump_i=1 -> pc_o stays 7, taken_o=0.
- halt_i=1 at pc=12 -> done_o=1 next cycle, pc_o holds 12. start=1 -> pc_o=0, done_o=0. Run to pc=1023 -> wraps to 0.
- sc_we_i=1, sc_d_i=1 -> sc_q_o=1. sc_clr_i=1 together with sc_we_i=1, sc_d_i=1 -> sc_q_o=0. reset asserted mid-RUN at pc=9 -> pc_o=0, sc_q_o=0, IDLE, LUT cleared.
- With PC_CYCLE_CNT_EN: start, 5 RUN cycles including 2 stalled, then halt -> cycle_cnt_o=5 held in DONE. Without the macro -> cycle_cnt_o=0 throughout.
